pp_column_loader: RTL
=====================

# pp_column_loader

Parametrised serial-to-parallel loader for the partial-product column array that feeds the compressor under test. It replaces per-width hand-instantiated column shift registers with one block generated from the multiplier width `N`: each of the `2N-1` columns has one serial input and a shift register whose depth follows the triangular profile of an N×N product. On top of plain shifting, it adds frame counting, a completion pulse, a fill level and an optional snapshot bank, so a bench can hold a complete operand frame steady while the next one streams in.

## Interface
- `N`, 27, multiplier operand width; columns `C = 2N-1`; column `c` depth `D(c) = min(c+1, 2N-1-c)`; total bits `T = N*N`
- `FCNT_W`, 8, width of the wrapping frame counter
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; synchronous and active-high
- `shift_en`  in  1  when high, every column shifts in its `src_in` bit this edge
- `src_in`  in  C  serial bit per column; bit `c` feeds column `c`
- `pp_out`  out  T  flattened column contents; column `c` at offset `S(c) = sum of D(k) for k<c`; within a column, bit 0 is the most recent input
- `frame_valid`  out  1  one-cycle pulse when a full frame is present on `pp_out`
- `busy`  out  1  high while in FILL
- `fill_level`  out  clog2(N+1)  shifts taken in the current frame, 0..N-1
- `frame_cnt`  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

## Operation
- A frame is exactly N accepted shifts (`shift_en`=1). Column `c` retains its last `D(c)` bits; earlier bits of that frame are shifted out and dropped.
- FSM states:
  - IDLE: reset state, `fill_level`=0, `busy`=0.
  - IDLE→FILL on a shift with N>1.
  - In FILL, each shift increments `fill_level`.
  - The shift that takes `fill_level` from N-1 to completion returns the FSM to IDLE with `fill_level`=0, registers `frame_valid`=1, and increments `frame_cnt`.
  - For N=1, every shift completes a frame and the FSM stays in IDLE.
- Back-to-back frames: a shift in the cycle `frame_valid` is high counts as shift 1 of the next frame.
- `shift_en`=0 holds every register. Gaps of any length inside a frame are legal.
- The shift bank has no clear other than `rst`. Its contents carry over between frames.
- Reset mid-frame: the partial frame is discarded and all state returns to reset values.

## Timing
- Reset values: `pp_out`=0, `frame_valid`=0, `busy`=0, `fill_level`=0, `frame_cnt`=0. The shift bank and the snapshot bank are both zeroed.
- `rst` has priority over `shift_en` in the same cycle.
- Shift at edge k updates the bank, `fill_level` and `busy` visibly from cycle k+1.
- Completing shift at edge k gives `frame_valid`=1 during cycle k+1 only, with the full frame on `pp_out` in the same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `PP_LOADER_SNAPSHOT_EN` defined:
  - A second T-bit bank loads the post-shift bank value on each completing edge.
  - `pp_out` is driven from this bank and stays constant until the next completion or `rst`.
- `PP_LOADER_SNAPSHOT_EN` undefined:
  - `pp_out` is the live shift bank.
  - It is only guaranteed to hold a complete frame while `frame_valid`=1, and changes on the next shift.

## Test plan
- N=4 (C=7, T=16). Assert `rst`, then apply 4 shifts with `src_in`=7'h7F → `frame_valid` pulses one cycle after the 4th shift, `pp_out`=16'hFFFF, `frame_cnt`=1, `busy`=0.
- N=4. Shift 1 with `src_in`=7'h7F, then shifts 2–4 with 0 → column 3 (offset 6, depth 4) = 4'b1000, columns 0 and 6 = 0, `fill_level` steps 1,2,3,0.
- N=4. Insert 5 idle cycles between shifts 2 and 3 → `fill_level` holds at 2, and `frame_valid` fires only after shift 4.
- N=4. Assert `rst` after shift 2, then run a full frame of ones → no pulse before shift 4 of the new frame, `frame_cnt`=1.
- N=4, `PP_LOADER_SNAPSHOT_EN` defined. Complete a frame of ones, then shift zeros → `pp_out` stays 16'hFFFF until the next completion. Without the macro, `pp_out` changes after the first zero shift.
- N=2, `FCNT_W`=2. Apply 8 continuous shifts → 4 pulses exactly 2 cycles apart, and `frame_cnt` wraps 3→0.

Source files
------------

// File: rtl/pp_column_loader.sv
`default_nettype none
// ============================================================================
// Module   : pp_column_loader
// Brief    : Serial-to-parallel loader for the 2N-1 partial-product columns of
//            an NxN product, with frame counting and optional snapshot bank.
//            Optional feature macro: PP_LOADER_SNAPSHOT_EN
// Revision : 1.0 - initial release
// ============================================================================
module pp_column_loader #(
    parameter int N      = 27,
    parameter int FCNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift_en,
    input  logic [2*N-2:0]            src_in,
    output logic [N*N-1:0]            pp_out,
    output logic                      frame_valid,
    output logic                      busy,
    output logic [$clog2(N+1)-1:0]    fill_level,
    output logic [FCNT_W-1:0]         frame_cnt
);

    localparam int c_cols = 2*N - 1;
    localparam int c_bits = N*N;
    localparam int c_fl_w = $clog2(N+1);
    localparam logic [c_fl_w-1:0] c_fill_last = c_fl_w'(N-1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_fill = 1'b1;

    function automatic int col_depth(input int c);
        return ((c + 1) < (2*N - 1 - c)) ? (c + 1) : (2*N - 1 - c);
    endfunction

    function automatic int col_off(input int c);
        int s;
        s = 0;
        for (int k = 0; k < c; k++) s += col_depth(k);
        return s;
    endfunction

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_fl_w-1:0]   r_fill;
    logic [c_fl_w-1:0]   w_fill_next;
    logic                w_complete;
    logic                r_valid;
    logic [FCNT_W-1:0]   r_fcnt;
    logic [c_bits-1:0]   r_bank;
    logic [c_bits-1:0]   w_bank_shifted;

    // Each column is a shift register whose newest bit sits at its lowest offset
    generate
        for (genvar c = 0; c < c_cols; c++) begin : g_col
            localparam int c_d = col_depth(c);
            localparam int c_o = col_off(c);
            if (c_d == 1) begin : g_single
                assign w_bank_shifted[c_o] = src_in[c];
            end else begin : g_multi
                assign w_bank_shifted[c_o +: c_d] = {r_bank[c_o +: c_d-1], src_in[c]};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A completing shift always lands in IDLE; for N=1 that is every shift
    always_comb begin
        w_state_next = r_state;
        if (shift_en) begin
            w_state_next = w_complete ? c_st_idle : c_st_fill;
        end
    end

    always_comb begin
        w_complete  = shift_en && (r_fill == c_fill_last);
        w_fill_next = r_fill;
        if (shift_en) begin
            w_fill_next = w_complete ? '0 : r_fill + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill  <= '0;
            r_valid <= 1'b0;
            r_fcnt  <= '0;
            r_bank  <= '0;
        end else begin
            r_fill  <= w_fill_next;
            r_valid <= w_complete;
            if (w_complete) r_fcnt <= r_fcnt + 1'b1;
            if (shift_en)   r_bank <= w_bank_shifted;
        end
    end

`ifdef PP_LOADER_SNAPSHOT_EN
    logic [c_bits-1:0] r_snap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_complete) begin
            r_snap <= w_bank_shifted;
        end
    end

    assign pp_out = r_snap;
`else
    assign pp_out = r_bank;
`endif

    assign frame_valid = r_valid;
    assign busy        = (r_state == c_st_fill);
    assign fill_level  = r_fill;
    assign frame_cnt   = r_fcnt;

endmodule
`default_nettype wire
